// File: rtl/pe_fp_sched_pkg.sv
// Shared types and helpers for the PE_FP sequencer: state encoding, default
// layer geometry and an address-width function.
package pe_sched_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_W,
        S_WAIT_W,
        S_FETCH,
        S_WAIT_FM,
        S_FIRE,
        S_WAIT_PE,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int OUT_H_DEF  = 16;
    localparam int OUT_W_DEF  = 16;
    localparam int N_FILT_DEF = 8;
    localparam int NPOS       = OUT_H_DEF * OUT_W_DEF;
    localparam int NOUT       = N_FILT_DEF * NPOS;

    // Never returns 0 so single-entry geometries still get a 1-bit address.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pe_fp_sched_lat_counter.sv
// Load-and-count-down dwell counter; 'last' flags the final cycle of a wait
// whose length was loaded on the cycle before the wait began.
module lat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt <= '0;
        else if (load)       cnt <= load_val;
        else if (cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign last = (cnt == W'(1));

endmodule

// File: rtl/pe_fp_sched.sv
// Sequencer for one PE_FP datapath: per filter, load weights, then walk every
// pooled position through fetch -> PE fire -> output write, one in flight.
module pe_fp_sched
    import pe_sched_pkg::*;
#(
    parameter int OUT_H   = OUT_H_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int N_FILT  = N_FILT_DEF,
    parameter int MEM_LAT = 1,
    parameter int PE_LAT  = 2,
    parameter int POS_W   = clog2(OUT_H * OUT_W),
    parameter int FILT_W  = clog2(N_FILT),
    parameter int OADDR_W = clog2(N_FILT * OUT_H * OUT_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               wt_rd_en,
    output logic [FILT_W-1:0]  wt_rd_addr,
    output logic               wt_ld,
    output logic               fm_rd_en,
    output logic [POS_W-1:0]   fm_rd_addr,
    output logic               pe_in_en,
    input  logic               out_ready,
    output logic               out_wr_en,
    output logic [OADDR_W-1:0] out_wr_addr,
    output logic [FILT_W-1:0]  cur_filt
);

    localparam int NUM_POS = OUT_H * OUT_W;
    localparam int NUM_OUT = N_FILT * NUM_POS;
    localparam int MAX_LAT = (MEM_LAT > PE_LAT) ? MEM_LAT : PE_LAT;
    localparam int CNT_W   = clog2(MAX_LAT + 1);

    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(NUM_POS - 1);
    localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(N_FILT - 1);
    localparam logic [OADDR_W-1:0] OADDR_LAST = OADDR_W'(NUM_OUT - 1);

    state_t              state, nxt;
    logic [FILT_W-1:0]   filt;
    logic [POS_W-1:0]    pos;
    logic [OADDR_W-1:0]  oaddr;
    logic                cnt_load, cnt_last;
    logic [CNT_W-1:0]    cnt_val;

    // One counter serves all three waits; they never overlap.
    lat_counter #(.W(CNT_W)) u_lat (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .last     (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt      = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            S_IDLE:    if (start) nxt = S_LOAD_W;
            S_LOAD_W: begin
                nxt      = S_WAIT_W;
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(MEM_LAT);
            end
            S_WAIT_W:  if (cnt_last) nxt = S_FETCH;
            S_FETCH: begin
                nxt      = (MEM_LAT == 1) ? S_FIRE : S_WAIT_FM;
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(MEM_LAT - 1);
            end
            S_WAIT_FM: if (cnt_last) nxt = S_FIRE;
            S_FIRE: begin
                nxt      = (PE_LAT == 1) ? S_WRITE : S_WAIT_PE;
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(PE_LAT - 1);
            end
            S_WAIT_PE: if (cnt_last) nxt = S_WRITE;
            S_WRITE: begin
                if (out_ready) begin
                    if (pos != POS_LAST)       nxt = S_FETCH;
                    else if (filt != FILT_LAST) nxt = S_LOAD_W;
                    else                        nxt = S_DONE;
                end
            end
            S_DONE:    nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
        if (abort) nxt = S_IDLE;
    end

    // Counters are cleared whenever the sequencer is, or is about to be, idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt  <= '0;
            pos   <= '0;
            oaddr <= '0;
        end else if (state == S_IDLE || nxt == S_IDLE) begin
            filt  <= '0;
            pos   <= '0;
            oaddr <= '0;
        end else if (state == S_WRITE && out_ready) begin
            oaddr <= (oaddr == OADDR_LAST) ? '0 : oaddr + 1'b1;
            if (pos == POS_LAST) begin
                pos  <= '0;
                filt <= (filt == FILT_LAST) ? '0 : filt + 1'b1;
            end else begin
                pos  <= pos + 1'b1;
            end
        end
    end

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign wt_rd_en    = (state == S_LOAD_W);
    assign wt_ld       = (state == S_WAIT_W) && cnt_last;
    assign fm_rd_en    = (state == S_FETCH);
    assign pe_in_en    = (state == S_FIRE);
    assign out_wr_en   = (state == S_WRITE) && out_ready;
    assign wt_rd_addr  = filt;
    assign cur_filt    = filt;
    assign fm_rd_addr  = pos;
    assign out_wr_addr = oaddr;

endmodule

// File: tb/tb_pe_fp_sched.sv
// Scoreboard bench: expected strobe events (kind, address, cycle after start
// accept) are queued per run; a monitor pops and compares each DUT strobe.
module tb_pe_fp_sched;

    localparam int K_RD = 0, K_LD = 1, K_FM = 2, K_PE = 3, K_WR = 4, K_DN = 5;

    typedef struct {
        int dut;
        int kind;
        int addr;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int t0 = 0;
    int nchk = 0;
    int nfail = 0;
    ev_t q[$];

    // DUT A: 2x3 positions, 2 filters, MEM_LAT=1, PE_LAT=2
    logic a_start = 0, a_abort = 0, a_out_ready = 1;
    logic a_busy, a_done, a_wt_rd_en, a_wt_ld, a_fm_rd_en, a_pe_in_en, a_out_wr_en;
    logic [0:0] a_wt_rd_addr, a_cur_filt;
    logic [2:0] a_fm_rd_addr;
    logic [3:0] a_out_wr_addr;

    pe_fp_sched #(.OUT_H(2), .OUT_W(3), .N_FILT(2), .MEM_LAT(1), .PE_LAT(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .busy(a_busy),
        .done(a_done), .wt_rd_en(a_wt_rd_en), .wt_rd_addr(a_wt_rd_addr), .wt_ld(a_wt_ld),
        .fm_rd_en(a_fm_rd_en), .fm_rd_addr(a_fm_rd_addr), .pe_in_en(a_pe_in_en),
        .out_ready(a_out_ready), .out_wr_en(a_out_wr_en), .out_wr_addr(a_out_wr_addr),
        .cur_filt(a_cur_filt)
    );

    // DUT B: same geometry, MEM_LAT=3, PE_LAT=1
    logic b_start = 0;
    logic b_busy, b_done, b_wt_rd_en, b_wt_ld, b_fm_rd_en, b_pe_in_en, b_out_wr_en;
    logic [0:0] b_wt_rd_addr, b_cur_filt;
    logic [2:0] b_fm_rd_addr;
    logic [3:0] b_out_wr_addr;

    pe_fp_sched #(.OUT_H(2), .OUT_W(3), .N_FILT(2), .MEM_LAT(3), .PE_LAT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(1'b0), .busy(b_busy),
        .done(b_done), .wt_rd_en(b_wt_rd_en), .wt_rd_addr(b_wt_rd_addr), .wt_ld(b_wt_ld),
        .fm_rd_en(b_fm_rd_en), .fm_rd_addr(b_fm_rd_addr), .pe_in_en(b_pe_in_en),
        .out_ready(1'b1), .out_wr_en(b_out_wr_en), .out_wr_addr(b_out_wr_addr),
        .cur_filt(b_cur_filt)
    );

    // DUT C: single position, single filter
    logic c_start = 0;
    logic c_busy, c_done, c_wt_rd_en, c_wt_ld, c_fm_rd_en, c_pe_in_en, c_out_wr_en;
    logic [0:0] c_wt_rd_addr, c_cur_filt, c_fm_rd_addr, c_out_wr_addr;

    pe_fp_sched #(.OUT_H(1), .OUT_W(1), .N_FILT(1), .MEM_LAT(1), .PE_LAT(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .abort(1'b0), .busy(c_busy),
        .done(c_done), .wt_rd_en(c_wt_rd_en), .wt_rd_addr(c_wt_rd_addr), .wt_ld(c_wt_ld),
        .fm_rd_en(c_fm_rd_en), .fm_rd_addr(c_fm_rd_addr), .pe_in_en(c_pe_in_en),
        .out_ready(1'b1), .out_wr_en(c_out_wr_en), .out_wr_addr(c_out_wr_addr),
        .cur_filt(c_cur_filt)
    );

    function automatic int a_outs();
        return int'({a_busy, a_done, a_wt_rd_en, a_wt_ld, a_fm_rd_en, a_pe_in_en,
                     a_out_wr_en, a_wt_rd_addr, a_fm_rd_addr, a_out_wr_addr, a_cur_filt});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int dut, input int kind, input int addr, input int t, input int cut);
        ev_t e;
        e.dut = dut; e.kind = kind; e.addr = addr; e.cyc = t;
        if (t <= cut) q.push_back(e);
    endtask

    // Expected strobe timeline of one layer, relative to the start-accept cycle.
    task automatic push_layer(input int dut, input int nf, input int npos, input int mem,
                              input int pel, input int stall_wr, input int stall_len,
                              input int cut);
        int t;
        int oa;
        int st;
        t = 1;
        oa = 0;
        for (int f = 0; f < nf; f++) begin
            push(dut, K_RD, f, t, cut);
            push(dut, K_LD, f, t + mem, cut);
            t += 1 + mem;
            for (int p = 0; p < npos; p++) begin
                st = (oa == stall_wr) ? stall_len : 0;
                push(dut, K_FM, p, t, cut);
                push(dut, K_PE, p, t + mem, cut);
                push(dut, K_WR, oa, t + mem + pel + st, cut);
                t += 1 + mem + pel + st;
                oa++;
            end
        end
        push(dut, K_DN, 0, t, cut);
    endtask

    task automatic observe(input int dut, input int kind, input int addr);
        ev_t e;
        nchk++;
        if (q.size() == 0) begin
            nfail++;
            $display("FAIL unexpected_event: got dut%0d kind%0d addr%0d at cycle %0d, expected none",
                     dut, kind, addr, cyc - t0);
        end else begin
            e = q.pop_front();
            if (e.dut != dut || e.kind != kind || e.addr != addr || e.cyc != cyc - t0) begin
                nfail++;
                $display("FAIL event: got dut%0d kind%0d addr%0d cycle%0d, expected dut%0d kind%0d addr%0d cycle%0d",
                         dut, kind, addr, cyc - t0, e.dut, e.kind, e.addr, e.cyc);
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (a_wt_rd_en)  observe(0, K_RD, int'(a_wt_rd_addr));
            if (a_wt_ld)     observe(0, K_LD, int'(a_cur_filt));
            if (a_fm_rd_en)  observe(0, K_FM, int'(a_fm_rd_addr));
            if (a_pe_in_en)  observe(0, K_PE, int'(a_fm_rd_addr));
            if (a_out_wr_en) observe(0, K_WR, int'(a_out_wr_addr));
            if (a_done)      observe(0, K_DN, 0);
            if (b_wt_rd_en)  observe(1, K_RD, int'(b_wt_rd_addr));
            if (b_wt_ld)     observe(1, K_LD, int'(b_cur_filt));
            if (b_fm_rd_en)  observe(1, K_FM, int'(b_fm_rd_addr));
            if (b_pe_in_en)  observe(1, K_PE, int'(b_fm_rd_addr));
            if (b_out_wr_en) observe(1, K_WR, int'(b_out_wr_addr));
            if (b_done)      observe(1, K_DN, 0);
            if (c_wt_rd_en)  observe(2, K_RD, int'(c_wt_rd_addr));
            if (c_wt_ld)     observe(2, K_LD, int'(c_cur_filt));
            if (c_fm_rd_en)  observe(2, K_FM, int'(c_fm_rd_addr));
            if (c_pe_in_en)  observe(2, K_PE, int'(c_fm_rd_addr));
            if (c_out_wr_en) observe(2, K_WR, int'(c_out_wr_addr));
            if (c_done)      observe(2, K_DN, 0);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_dut(input int dut);
        tick(1);
        case (dut)
            0:       a_start = 1'b1;
            1:       b_start = 1'b1;
            default: c_start = 1'b1;
        endcase
        t0 = cyc;
        tick(1);
        a_start = 1'b0;
        b_start = 1'b0;
        c_start = 1'b0;
    endtask

    task automatic goto(input int r);
        while (cyc - t0 < r) tick(1);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(name, q.size(), 0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        #3;
        check("reset_outputs_a", a_outs(), 0);
        check("reset_busy_b", int'(b_busy), 0);
        check("reset_busy_c", int'(c_busy), 0);
        tick(2);
        rst_n = 1'b1;

        // Nominal layer; a second start mid-run must be ignored.
        push_layer(0, 2, 6, 1, 2, -1, 0, 1000);
        start_dut(0);
        goto(10);
        check("busy_mid_run", int'(a_busy), 1);
        a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        drain("nominal_drain", 100);
        tick(1);
        check("idle_after_done", int'(a_busy), 0);

        // Backpressure on the write of address 8 (filt 1, pos 2).
        push_layer(0, 2, 6, 1, 2, 8, 4, 1000);
        start_dut(0);
        goto(40);
        a_out_ready = 1'b0;
        goto(42);
        check("stall_addr", int'(a_out_wr_addr), 8);
        check("stall_wr_en", int'(a_out_wr_en), 0);
        goto(44);
        a_out_ready = 1'b1;
        drain("backpressure_drain", 100);

        // Abort during WAIT_PE of filt 1, pos 3.
        tick(2);
        push_layer(0, 2, 6, 1, 2, -1, 0, 43);
        start_dut(0);
        goto(43);
        a_abort = 1'b1;
        tick(1);
        a_abort = 1'b0;
        check("abort_busy", int'(a_busy), 0);
        check("abort_done", int'(a_done), 0);
        tick(3);
        drain("abort_drain", 5);

        // start and abort together stay idle.
        a_start = 1'b1;
        a_abort = 1'b1;
        tick(1);
        a_start = 1'b0;
        a_abort = 1'b0;
        check("start_abort_idle", int'(a_busy), 0);

        // Rerun after abort starts again from address 0.
        push_layer(0, 2, 6, 1, 2, -1, 0, 1000);
        start_dut(0);
        drain("rerun_drain", 100);

        // Async reset in WAIT_PE of filt 1, pos 1.
        tick(2);
        push_layer(0, 2, 6, 1, 2, -1, 0, 34);
        start_dut(0);
        goto(35);
        check("pre_rst_filt", int'(a_cur_filt), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", a_outs(), 0);
        tick(1);
        rst_n = 1'b1;
        check("async_rst_queue", q.size(), 0);

        // MEM_LAT=3, PE_LAT=1: five cycles per position.
        tick(2);
        push_layer(1, 2, 6, 3, 1, -1, 0, 1000);
        start_dut(1);
        drain("lat_b_drain", 120);
        tick(1);
        check("lat_b_idle", int'(b_busy), 0);

        // Single-position, single-filter corner.
        tick(2);
        push_layer(2, 1, 1, 1, 2, -1, 0, 1000);
        start_dut(2);
        drain("corner_drain", 20);
        tick(1);
        check("corner_idle", int'(c_busy), 0);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
